alu_seq: RTL



---
 rtl/alu_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered ALU with architectural S/Z/C/V flags and an iterative one-bit-per-cycle shifter.
// Non-shift ops complete in one cycle; shifts by n>0 hold in_ready low for n cycles.
module alu_seq #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic               result_we,
  output logic [3:0]         flags,
  output logic               err
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned XW  = WIDTH + 1;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_ADC = 4'h7;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SLR = 2'b01;
  localparam logic [1:0] SH_SRL = 2'b10;
  localparam logic [1:0] SH_SRA = 2'b11;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   work, work_nx;
  logic [SHAMT_W-1:0] cnt, cnt_nx;
  logic [1:0]         sop, sop_nx;
  logic [WIDTH-1:0]   result_nx;
  logic [3:0]         flags_nx;
  logic               out_valid_nx, result_we_nx, err_nx, in_ready_nx;

  logic               cin;
  logic [WIDTH:0]     add_sum, sub_dif;
  logic               add_v, sub_v;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_we, alu_err;
  logic               shift_start;
  logic [WIDTH-1:0]   step;
  logic               step_out;

  // ADC uses the flag register directly; a just-completed op has already written it.
  assign cin     = (op == OP_ADC) & flags[1];
  assign add_sum = {1'b0, a} + {1'b0, b} + XW'(cin);
  assign sub_dif = {1'b0, a} - {1'b0, b};
  assign add_v   = (a[MSB] == b[MSB]) && (add_sum[MSB] != a[MSB]);
  assign sub_v   = (a[MSB] != b[MSB]) && (sub_dif[MSB] != a[MSB]);
  assign shift_start = (op[3:2] == 2'b10) && (shamt != '0);

  // Single-cycle operation decode.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_we  = 1'b1;
    alu_err = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        alu_res = add_sum[MSB:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = add_v;
      end
      OP_SUB, OP_CMP: begin
        alu_res = sub_dif[MSB:0];
        alu_c   = sub_dif[WIDTH];
        alu_v   = sub_v;
        alu_we  = (op != OP_CMP);
      end
      OP_AND:                        alu_res = a & b;
      OP_OR:                         alu_res = a | b;
      OP_XOR:                        alu_res = a ^ b;
      OP_MOV:                        alu_res = b;
      4'h8, 4'h9, 4'hA, 4'hB:        alu_res = b;
      default: begin
        alu_we  = 1'b0;
        alu_err = 1'b1;
      end
    endcase
  end

  // One-bit shift step of the working register and the bit it drops.
  always_comb begin
    step     = work;
    step_out = 1'b0;
    case (sop)
      SH_SLL: begin step = {work[MSB-1:0], 1'b0};      step_out = work[MSB]; end
      SH_SLR: begin step = {work[MSB-1:0], work[MSB]}; step_out = 1'b0;      end
      SH_SRL: begin step = {1'b0, work[MSB:1]};        step_out = work[0];   end
      SH_SRA: begin step = {work[MSB], work[MSB:1]};   step_out = work[0];   end
      default: ;
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_nx     = state;
    work_nx      = work;
    cnt_nx       = cnt;
    sop_nx       = sop;
    result_nx    = result;
    flags_nx     = flags;
    out_valid_nx = 1'b0;
    result_we_nx = 1'b0;
    err_nx       = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (shift_start) begin
            work_nx  = b;
            cnt_nx   = shamt;
            sop_nx   = op[1:0];
            state_nx = SHIFT;
          end else begin
            out_valid_nx = 1'b1;
            result_nx    = alu_res;
            result_we_nx = alu_we;
            err_nx       = alu_err;
            if (!alu_err) flags_nx = {alu_res[MSB], alu_res == '0, alu_c, alu_v};
          end
        end
      end
      SHIFT: begin
        work_nx = step;
        cnt_nx  = cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) begin
          state_nx     = IDLE;
          out_valid_nx = 1'b1;
          result_we_nx = 1'b1;
          result_nx    = step;
          flags_nx     = {step[MSB], step == '0, step_out, 1'b0};
        end
      end
      default: state_nx = IDLE;
    endcase
    in_ready_nx = (state_nx == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      sop       <= '0;
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
      result_we <= 1'b0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nx;
      work      <= work_nx;
      cnt       <= cnt_nx;
      sop       <= sop_nx;
      result    <= result_nx;
      flags     <= flags_nx;
      out_valid <= out_valid_nx;
      result_we <= result_we_nx;
      err       <= err_nx;
      in_ready  <= in_ready_nx;
    end
  end

endmodule
